// File: rtl/post_deinterleaver.sv
// post_deinterleaver
// Receive-side inverse of the transmit pre-interleaver. Codewords arrive
// serially, one codeword after another. Each block of NUM_CODEWORDS codewords
// is written into one half of a ping-pong buffer. The block is then read back
// index-major (word i of every codeword, then word i+1), which restores the
// original payload order.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   s_axis_tdata    codeword-serial input word
//   s_axis_tvalid   input word valid
//   s_axis_tready   input accepted while the current write bank is not full
//   m_axis_tdata    de-interleaved output word (registered)
//   m_axis_tvalid   output word valid (registered)
//   m_axis_tready   downstream ready
//   m_axis_tlast    marks the final word of each block
module post_deinterleaver #(
  parameter int CODEWORD_SIZE_IN_32 = 65,
  parameter int NUM_CODEWORDS       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast
);

  localparam int S     = CODEWORD_SIZE_IN_32;
  localparam int N     = NUM_CODEWORDS;
  localparam int B     = N * S;
  localparam int IDX_W = $clog2(S);
  localparam int CW_W  = $clog2(N);
  localparam int AW    = $clog2(2 * B);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(S - 1);
  localparam logic [CW_W-1:0]  CW_LAST  = CW_W'(N - 1);

  // Two banks of B words each. Bank 1 occupies the upper half.
  logic [31:0] mem [0:2*B-1];

  logic             wr_bank_q, wr_bank_d;
  logic [CW_W-1:0]  wr_cw_q, wr_cw_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             rd_bank_q, rd_bank_d;
  logic [CW_W-1:0]  rd_cw_q, rd_cw_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [1:0]       bank_full_q, bank_full_d;
  logic             tvalid_q, tvalid_d;
  logic             tlast_q, tlast_d;
  logic [31:0]      tdata_q;

  logic          s_ready;
  logic          wr_en;
  logic          wr_last;
  logic          rd_load;
  logic          rd_last;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  assign s_ready = !bank_full_q[wr_bank_q];
  assign wr_en   = s_axis_tvalid && s_ready;
  assign wr_last = (wr_cw_q == CW_LAST) && (wr_idx_q == IDX_LAST);
  // The output register may load when it is empty or is being drained this cycle.
  assign rd_load = bank_full_q[rd_bank_q] && (!tvalid_q || m_axis_tready);
  assign rd_last = (rd_cw_q == CW_LAST) && (rd_idx_q == IDX_LAST);

  assign wr_addr = (wr_bank_q ? AW'(B) : AW'(0)) + AW'(wr_cw_q) * AW'(S) + AW'(wr_idx_q);
  assign rd_addr = (rd_bank_q ? AW'(B) : AW'(0)) + AW'(rd_cw_q) * AW'(S) + AW'(rd_idx_q);

  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_cw_d     = wr_cw_q;
    wr_idx_d    = wr_idx_q;
    rd_bank_d   = rd_bank_q;
    rd_cw_d     = rd_cw_q;
    rd_idx_d    = rd_idx_q;
    bank_full_d = bank_full_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;

    // Writer: codeword-serial, index runs fastest.
    if (wr_en) begin
      if (wr_last) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_bank_d              = !wr_bank_q;
        wr_cw_d                = '0;
        wr_idx_d               = '0;
      end else if (wr_idx_q == IDX_LAST) begin
        wr_idx_d = '0;
        wr_cw_d  = wr_cw_q + 1'b1;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end

    // Reader: index-major, codeword runs fastest. A set by the writer and a
    // clear here never target the same bit: a set needs the bit clear and a
    // clear needs it set.
    if (rd_load) begin
      tvalid_d = 1'b1;
      tlast_d  = rd_last;
      if (rd_last) begin
        bank_full_d[rd_bank_q] = 1'b0;
        rd_bank_d              = !rd_bank_q;
        rd_cw_d                = '0;
        rd_idx_d               = '0;
      end else if (rd_cw_q == CW_LAST) begin
        rd_cw_d  = '0;
        rd_idx_d = rd_idx_q + 1'b1;
      end else begin
        rd_cw_d = rd_cw_q + 1'b1;
      end
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      wr_cw_q     <= '0;
      wr_idx_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_cw_q     <= '0;
      rd_idx_q    <= '0;
      bank_full_q <= 2'b00;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_cw_q     <= wr_cw_d;
      wr_idx_q    <= wr_idx_d;
      rd_bank_q   <= rd_bank_d;
      rd_cw_q     <= rd_cw_d;
      rd_idx_q    <= rd_idx_d;
      bank_full_q <= bank_full_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

  // Storage array: no reset, so it can map onto block RAM. Stale contents are
  // never emitted, because only full banks are read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= s_axis_tdata;
    end
  end

  // The output data register is the synchronous RAM read port. It loads
  // straight from the array instead of through a _d net, which keeps the
  // read inferable as block RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdata_q <= '0;
    end else if (rd_load) begin
      tdata_q <= mem[rd_addr];
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

endmodule
